apb_cmd_sequencer: RTL
======================

Name: apb_cmd_sequencer

Overview:
- Upstream command stage for apb_top. Accepts a valid/ready stream of read/write commands and buffers them in a small FIFO.
- Drives apb_top's TRANSFER/read/write/address/data inputs one transfer at a time.
- Detects transfer completion from psel1/PENABLE/pready1 and returns a valid/ready response carrying read data and error status.
- A watchdog converts hung transfers into error responses.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT, 16, maximum cycles in ISSUE before a timeout response; minimum 4.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- PCLK  in  1  system clock, all flops rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR captured at completion, or timeout.
- rsp_timeout  out  1  watchdog expired.
- TRANSFER  out  1  to apb_top.
- write  out  1  to apb_top.
- read  out  1  to apb_top.
- apb_write_address  out  ADDR_W  to apb_top.
- apb_write_data  out  DATA_W  to apb_top.
- apb_read_address  out  ADDR_W  to apb_top.
- psel1  in  1  from apb_top.
- PENABLE  in  1  from apb_top.
- pready1  in  1  from apb_top.
- PSLVERR  in  1  from apb_top.
- apb_read_out  in  DATA_W  from apb_top.

Behaviour:
- Reset (PRESET=1, async): FIFO empty, FSM=IDLE, watchdog=0. All outputs 0 except cmd_ready=1. Reset mid-transfer drops TRANSFER immediately. The in-flight command is lost and no response is produced.
- All outputs to apb_top and all rsp_* outputs are registered.
- FIFO push: cmd_valid && cmd_ready. Entry contents: {write, addr, wdata}. An entry becomes visible to the FSM the cycle after the push.
- FIFO pop: only in IDLE when non-empty. Push and pop in the same cycle are legal; occupancy is unchanged. cmd_ready is derived from registered occupancy, so a push while full is impossible.
- Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If the FIFO is non-empty: pop and latch the command.
  - Next cycle: TRANSFER=1; write=cmd.write; read=!cmd.write.
  - Write command: apb_write_address=addr, apb_write_data=wdata, apb_read_address=0.
  - Read command: apb_read_address=addr; apb_write_address and apb_write_data =0.
  - Go to ISSUE; watchdog cleared.
- ISSUE:
  - Outputs held stable; watchdog increments each cycle.
  - Completion = psel1 && PENABLE && pready1.
  - On completion: capture rsp_rdata (apb_read_out if read, else 0), rsp_err=PSLVERR, rsp_timeout=0, rsp_write. TRANSFER/read/write drop to 0 next cycle. Go to RESP.
  - If the watchdog reaches TIMEOUT-1 without completion: rsp_err=1, rsp_timeout=1, rsp_rdata=0. TRANSFER dropped. Go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - rsp_valid=1, payload stable, until rsp_ready is sampled high. Then rsp_valid=0 next cycle; go to IDLE.
  - No new transfer is issued while a response is pending (strict one-outstanding ordering).
  - The FIFO keeps accepting commands in every state.
- Best-case latency for a command pushed at cycle 0 into an empty, idle block:
  - Cycle 1: pop (IDLE).
  - Cycle 2: TRANSFER=1.
  - rsp_valid asserts the cycle after completion is sampled.
- apb_top outputs are 0 whenever FSM ≠ ISSUE.
- Responses are returned in command order.

Decomposition:
- Package apb_seq_pkg:
  - state enum {IDLE, ISSUE, RESP}
  - cmd_t struct {write, addr, wdata}
  - rsp_t struct {write, rdata, err, timeout}
  - width localparams
- One sub-module, apb_cmd_fifo: parameterised synchronous FIFO of cmd_t with push/pop/full/empty/count, async active-high reset.
- The FSM, watchdog and output registers stay in the top module.

Test Plan:
- Single write: addr=0x10, wdata=0xDEADBEEF, slave ready → one TRANSFER pulse train with write=1, apb_write_address=0x10; response rsp_write=1, rsp_err=0, rsp_rdata=0.
- Write then read: write 0x20=0x12345678, then read 0x20 → second response rsp_rdata=0x12345678, rsp_err=0; response order preserved.
- Back-pressure: push 5 commands with rsp_ready=0 → cmd_ready=0 after the 4th entry is held and the 1st is in RESP. Raise rsp_ready → all 5 responses arrive in order.
- Timeout: force pready1=0 → response arrives with rsp_err=1, rsp_timeout=1, rsp_rdata=0, exactly TIMEOUT cycles after TRANSFER rose. TRANSFER=0 afterwards.
- Slave error: PSLVERR=1 at completion of a read of 0x40 → rsp_err=1, rsp_timeout=0.
- Async reset asserted mid-ISSUE → TRANSFER/read/write=0 and rsp_valid=0 without a clock edge. After release, cmd_ready=1 and the FIFO is empty.

Source files
------------

// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: FSM states, command and response records.
package apb_seq_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    // An APB access finishes in the access phase once the slave is ready.
    function automatic logic apb_done(input logic sel, input logic enable, input logic ready);
        return sel && enable && ready;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; wrap bit on each pointer separates full from empty.
module apb_cmd_fifo
    import apb_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is pure data; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Buffers read/write commands and issues them to apb_top one at a time, with a
// watchdog that turns a hung transfer into an error response.
module apb_cmd_sequencer
    import apb_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int ADDR_W     = CMD_ADDR_W,
    parameter int DATA_W     = CMD_DATA_W
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              TRANSFER,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] apb_write_address,
    output logic [DATA_W-1:0] apb_write_data,
    output logic [ADDR_W-1:0] apb_read_address,
    input  logic              psel1,
    input  logic              PENABLE,
    input  logic              pready1,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] apb_read_out
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t    state;
    logic [WD_W-1:0] wdog;
    rsp_t      rsp_q;
    cmd_t      cmd_in;
    cmd_t      head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_pop;
    logic      done;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

    // Record widths come from the package, so ADDR_W/DATA_W must match it.
    assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign done      = apb_done(psel1, PENABLE, pready1);

    assign rsp_write   = rsp_q.write;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (PCLK),
        .rst       (PRESET),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state             <= IDLE;
            wdog              <= '0;
            TRANSFER          <= 1'b0;
            write             <= 1'b0;
            read              <= 1'b0;
            apb_write_address <= '0;
            apb_write_data    <= '0;
            apb_read_address  <= '0;
            rsp_valid         <= 1'b0;
            rsp_q             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        TRANSFER          <= 1'b1;
                        write             <= head.write;
                        read              <= !head.write;
                        apb_write_address <= head.write ? head.addr  : '0;
                        apb_write_data    <= head.write ? head.wdata : '0;
                        apb_read_address  <= head.write ? '0 : head.addr;
                        wdog              <= '0;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Completion takes priority over a simultaneous watchdog expiry.
                    if (done || wdog == WD_LAST) begin
                        rsp_q.write       <= write;
                        rsp_q.rdata       <= (done && read) ? apb_read_out : '0;
                        rsp_q.err         <= done ? PSLVERR : 1'b1;
                        rsp_q.timeout     <= !done;
                        rsp_valid         <= 1'b1;
                        TRANSFER          <= 1'b0;
                        write             <= 1'b0;
                        read              <= 1'b0;
                        apb_write_address <= '0;
                        apb_write_data    <= '0;
                        apb_read_address  <= '0;
                        state             <= RESP;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
